dispatch_queue: RTL
===================

# dispatch_queue

Buffered, parametrised dispatch stage between ID and the three reservation stations (ALU RS, LoadStore RS, Branch RS). It resolves source operands from RegFile, ROB and the CDBs at enqueue, holds up to DEPTH decoded instructions in program order, and keeps waking held operands from the CDBs. It issues the head entry to the RS matching its class, with per-class backpressure and a mispredict flush.

## Interface
- DEPTH, 4: queue entries, power of two, ≥2
- CDB_N, 2: number of CDB broadcast ports (ALU, LSU)
- TAG_W, 4: ROB tag width; tag 0 is never a valid producer
- DATA_W, 32: operand and immediate width
- OP_W, 6: internal opcode width
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global ready; low freezes all state
- clear_i  in  1  mispredict flush
- disp_en_i  in  1  ID offers an instruction this cycle
- disp_ready_o  out  1  queue accepts it (count != DEPTH)
- op_i, imm_i, pc_i, des_i, bp_i  in  OP_W/DATA_W/DATA_W/TAG_W/1  decoded instruction
- reg1_valid_i, reg1_tag_i, reg1_data_i  in  1/TAG_W/DATA_W  RegFile source 1 (same set for reg2)
- ROB_reg1_re_o, ROB_reg1_tag_o  out  1/TAG_W  ROB lookup (same for reg2)
- ROB_reg1_valid_i, ROB_reg1_data_i  in  1/DATA_W  ROB result (same for reg2)
- cdb_valid_i, cdb_tag_i, cdb_data_i  in  CDB_N / CDB_N*TAG_W / CDB_N*DATA_W  broadcasts
- alu_full_i, ls_full_i, br_full_i  in  1  RS cannot accept
- alu_we_o, ls_we_o, br_we_o  out  1  issue strobe, one-hot or zero
- op_o, imm_o, pc_o, des_o, bp_o  out  shared head payload
- reg1_valid_o, reg1_tag_o, reg1_data_o, reg2_*  out  head operands

## Operation
- Class from op_i: LS if LB ≤ op ≤ SW, BR if JAL ≤ op ≤ BGEU, else ALU. Stored in the entry.
- ROB lookup is combinational from ID inputs. re_o = disp_en_i & !regN_valid_i. tag_o = regN_tag_i when re_o is set, else 0.
- Enqueue operand priority: RegFile valid, then ROB valid, then any CDB tag match this cycle, else store invalid with the tag.
- Every cycle, each held invalid operand compares its tag against all valid CDB ports and captures the data on a match. Two ports never carry the same tag.
- Issue condition: head valid & !full of its class & rdy_in. Assert exactly that class's we_o, then pop.
- Issue-cycle forwarding: payload operands also apply this cycle's CDB matches combinationally, so an RS never misses a broadcast.
- Enqueue condition: disp_en_i & disp_ready_o & rdy_in & !clear_i. There is no pass-through at full, so a simultaneous pop does not admit a new entry.
- When head is empty, all payload outputs are 0 and all we_o are 0.

## Timing
- Reset or clear_i (at the next edge): head = tail = count = 0, all entry valid bits = 0. All outputs read 0 during and after. clear_i beats enqueue and issue in the same cycle.
- Latency: an instruction enqueued at edge t is issuable in cycle t+1 at the earliest, which is one cycle minimum dispatch latency.
- Throughput: 1 enqueue plus 1 issue per cycle.
- Pointers wrap modulo DEPTH.
- count increments on enqueue only, decrements on issue only, and is unchanged when both occur.
- rdy_in low: no state changes and we_o are forced to 0. disp_ready_o still reflects count.
- A CDB wake and an issue in the same cycle are both honoured. The issued payload carries the woken data.

## Structure
- Shared package holds:
  - opcode localparams and the LB/SW/JAL/BGEU bounds
  - the class enum {ALU, LS, BR}
  - TAG_W/DATA_W defaults
  - the Valid/Invalid/Enable/Disable/Null constants
- One sub-module, dispatch_operand_slot. It holds valid/tag/data for one operand, performs the CDB_N-way match and capture, and exposes a forwarded view. There are 2×DEPTH instances.

## Test plan
- Reset, then ADD with reg1 valid=5 and reg2 valid=7, alu_full_i=0: alu_we_o=1 in the cycle after enqueue with data 5/7; ls_we_o and br_we_o stay 0.
- LW with reg1 tag 3 invalid and ROB tag 3 valid=0x100: ROB_reg1_re_o=1 and tag 3 at enqueue; issued on ls_we_o with reg1_valid_o=1 and data 0x100.
- BEQ with reg2 tag 6 pending, br_full_i=1 for 3 cycles, CDB1 broadcasts tag 6 = 0x2A in cycle 2: br_we_o=1 in cycle 4 with reg2 valid data 0x2A.
- Fill 4 entries with ls_full_i=1: disp_ready_o=0 and a 5th offer is dropped. Release ls_full_i: 4 in-order issues, then disp_ready_o=1.
- Head stalled on CDB tag 2 while CDB0 broadcasts tag 2 = 9 in the issue cycle: payload shows reg1 valid data 9 on the same cycle.
- 3 entries queued, clear_i asserted with a concurrent disp_en_i: next cycle count=0, all we_o=0, and the concurrent instruction is not enqueued.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Shared definitions for the dispatch queue.
// - Internal opcode numbering and the class range bounds (LS: LB..SW, BR: JAL..BGEU).
// - Instruction class enum used to steer an entry to its reservation station.
// - Default operand widths and the generic Valid/Invalid/Enable/Disable/Null constants.
// - op_class(): maps an opcode to its class.
package dispatch_queue_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;

  // Opcode map: branches and loads/stores occupy contiguous ranges.
  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_LUI   = 1;
  localparam int unsigned OP_AUIPC = 2;
  localparam int unsigned OP_JAL   = 3;
  localparam int unsigned OP_JALR  = 4;
  localparam int unsigned OP_BEQ   = 5;
  localparam int unsigned OP_BNE   = 6;
  localparam int unsigned OP_BLT   = 7;
  localparam int unsigned OP_BGE   = 8;
  localparam int unsigned OP_BLTU  = 9;
  localparam int unsigned OP_BGEU  = 10;
  localparam int unsigned OP_LB    = 11;
  localparam int unsigned OP_LH    = 12;
  localparam int unsigned OP_LW    = 13;
  localparam int unsigned OP_LBU   = 14;
  localparam int unsigned OP_LHU   = 15;
  localparam int unsigned OP_SB    = 16;
  localparam int unsigned OP_SH    = 17;
  localparam int unsigned OP_SW    = 18;
  localparam int unsigned OP_ADDI  = 19;
  localparam int unsigned OP_ADD   = 20;
  localparam int unsigned OP_SUB   = 21;
  localparam int unsigned OP_AND   = 22;
  localparam int unsigned OP_OR    = 23;
  localparam int unsigned OP_XOR   = 24;

  localparam int unsigned OP_LS_LO = OP_LB;
  localparam int unsigned OP_LS_HI = OP_SW;
  localparam int unsigned OP_BR_LO = OP_JAL;
  localparam int unsigned OP_BR_HI = OP_BGEU;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LS  = 2'd1,
    CLS_BR  = 2'd2
  } cls_e;

  localparam logic        VALID   = 1'b1;
  localparam logic        INVALID = 1'b0;
  localparam logic        ENABLE  = 1'b1;
  localparam logic        DISABLE = 1'b0;
  localparam int unsigned NULL_V  = 0;

  function automatic cls_e op_class(input int unsigned op);
    if (op >= OP_LS_LO && op <= OP_LS_HI) begin
      return CLS_LS;
    end else if (op >= OP_BR_LO && op <= OP_BR_HI) begin
      return CLS_BR;
    end
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/dispatch_operand_slot.sv
// One held source operand (valid/tag/data) of a dispatch queue entry.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   en_i              global ready; low freezes the slot
//   clear_i           flush: slot returns to invalid/zero
//   load_i            capture load_* (entry is being enqueued)
//   load_valid_i/tag_i/data_i  operand as resolved at enqueue
//   cdb_valid_i/tag_i/data_i   CDB broadcast ports (packed, port k at slice k)
//   fwd_valid_o/tag_o/data_o   held operand with this cycle's CDB match applied
// A valid operand always carries a null tag so the forwarded view is canonical.
module dispatch_operand_slot
  import dispatch_queue_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CDB_N  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic                    load_valid_i,
  input  logic [TAG_W-1:0]        load_tag_i,
  input  logic [DATA_W-1:0]       load_data_i,
  input  logic [CDB_N-1:0]        cdb_valid_i,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag_i,
  input  logic [CDB_N*DATA_W-1:0] cdb_data_i,
  output logic                    fwd_valid_o,
  output logic [TAG_W-1:0]        fwd_tag_o,
  output logic [DATA_W-1:0]       fwd_data_o
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  // Ports never carry the same tag, so at most one can hit.
  always_comb begin
    hit      = INVALID;
    hit_data = '0;
    for (int k = 0; k < CDB_N; k++) begin
      if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == tag_q)) begin
        hit      = VALID;
        hit_data = cdb_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = INVALID;
      tag_d   = TAG_W'(NULL_V);
      data_d  = DATA_W'(NULL_V);
    end else if (load_i) begin
      valid_d = load_valid_i;
      tag_d   = load_tag_i;
      data_d  = load_data_i;
    end else if (!valid_q && hit) begin
      valid_d = VALID;
      tag_d   = TAG_W'(NULL_V);
      data_d  = hit_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= INVALID;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign fwd_valid_o = valid_q | hit;
  assign fwd_tag_o   = (valid_q | hit) ? TAG_W'(NULL_V) : tag_q;
  assign fwd_data_o  = valid_q ? data_q : (hit ? hit_data : data_q);

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between ID and the ALU/LoadStore/Branch reservation
// stations. Operands are resolved at enqueue (RegFile > ROB > CDB), woken from
// the CDBs while held, and forwarded from the CDBs again on the issue cycle.
// Ports:
//   clk_in, rst_in, rdy_in, clear_i      clock, sync reset, global ready, flush
//   disp_en_i / disp_ready_o             ID offer / queue not full
//   op_i, imm_i, pc_i, des_i, bp_i       decoded instruction
//   regN_valid_i/tag_i/data_i            RegFile sources (N = 1, 2)
//   ROB_regN_re_o/tag_o, ROB_regN_valid_i/data_i   ROB operand lookup
//   cdb_valid_i/tag_i/data_i             CDB broadcasts (packed, port k at slice k)
//   alu/ls/br_full_i, alu/ls/br_we_o     RS backpressure / issue strobes
//   op_o .. bp_o, regN_valid_o/tag_o/data_o   head payload (zero when empty)
// Handshake: an instruction moves into the queue on a cycle where disp_en_i,
// disp_ready_o and rdy_in are high and clear_i is low; it moves to an RS on a
// cycle where its we_o is high, which happens only when that RS is not full.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CDB_N  = 2,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_i,
  input  logic                    disp_en_i,
  output logic                    disp_ready_o,
  input  logic [OP_W-1:0]         op_i,
  input  logic [DATA_W-1:0]       imm_i,
  input  logic [DATA_W-1:0]       pc_i,
  input  logic [TAG_W-1:0]        des_i,
  input  logic                    bp_i,
  input  logic                    reg1_valid_i,
  input  logic [TAG_W-1:0]        reg1_tag_i,
  input  logic [DATA_W-1:0]       reg1_data_i,
  input  logic                    reg2_valid_i,
  input  logic [TAG_W-1:0]        reg2_tag_i,
  input  logic [DATA_W-1:0]       reg2_data_i,
  output logic                    ROB_reg1_re_o,
  output logic [TAG_W-1:0]        ROB_reg1_tag_o,
  input  logic                    ROB_reg1_valid_i,
  input  logic [DATA_W-1:0]       ROB_reg1_data_i,
  output logic                    ROB_reg2_re_o,
  output logic [TAG_W-1:0]        ROB_reg2_tag_o,
  input  logic                    ROB_reg2_valid_i,
  input  logic [DATA_W-1:0]       ROB_reg2_data_i,
  input  logic [CDB_N-1:0]        cdb_valid_i,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag_i,
  input  logic [CDB_N*DATA_W-1:0] cdb_data_i,
  input  logic                    alu_full_i,
  input  logic                    ls_full_i,
  input  logic                    br_full_i,
  output logic                    alu_we_o,
  output logic                    ls_we_o,
  output logic                    br_we_o,
  output logic [OP_W-1:0]         op_o,
  output logic [DATA_W-1:0]       imm_o,
  output logic [DATA_W-1:0]       pc_o,
  output logic [TAG_W-1:0]        des_o,
  output logic                    bp_o,
  output logic                    reg1_valid_o,
  output logic [TAG_W-1:0]        reg1_tag_o,
  output logic [DATA_W-1:0]       reg1_data_o,
  output logic                    reg2_valid_o,
  output logic [TAG_W-1:0]        reg2_tag_o,
  output logic [DATA_W-1:0]       reg2_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;

  // Payload is qualified by ent_valid_q, so it needs no reset.
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [DATA_W-1:0] imm_q  [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [TAG_W-1:0]  des_q  [DEPTH];
  logic              bp_q   [DEPTH];
  cls_e              cls_q  [DEPTH];

  logic              enq, issue, show, head_valid, class_full;
  cls_e              head_cls;

  // Per-source views (index 0 = reg1, 1 = reg2).
  logic              src_rf_v   [2];
  logic [TAG_W-1:0]  src_rf_tag [2];
  logic [DATA_W-1:0] src_rf_data[2];
  logic              src_rob_v  [2];
  logic [DATA_W-1:0] src_rob_data[2];
  logic              enq_v      [2];
  logic [TAG_W-1:0]  enq_tag    [2];
  logic [DATA_W-1:0] enq_data   [2];

  logic [DEPTH-1:0]  fwd_v      [2];
  logic [TAG_W-1:0]  fwd_tag    [2][DEPTH];
  logic [DATA_W-1:0] fwd_data   [2][DEPTH];

  assign src_rf_v[0]     = reg1_valid_i;
  assign src_rf_tag[0]   = reg1_tag_i;
  assign src_rf_data[0]  = reg1_data_i;
  assign src_rob_v[0]    = ROB_reg1_valid_i;
  assign src_rob_data[0] = ROB_reg1_data_i;
  assign src_rf_v[1]     = reg2_valid_i;
  assign src_rf_tag[1]   = reg2_tag_i;
  assign src_rf_data[1]  = reg2_data_i;
  assign src_rob_v[1]    = ROB_reg2_valid_i;
  assign src_rob_data[1] = ROB_reg2_data_i;

  assign ROB_reg1_re_o  = disp_en_i & ~reg1_valid_i;
  assign ROB_reg1_tag_o = ROB_reg1_re_o ? reg1_tag_i : TAG_W'(NULL_V);
  assign ROB_reg2_re_o  = disp_en_i & ~reg2_valid_i;
  assign ROB_reg2_tag_o = ROB_reg2_re_o ? reg2_tag_i : TAG_W'(NULL_V);

  // Operand resolution at enqueue: RegFile, then ROB, then a same-cycle CDB hit.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      enq_v[s]    = INVALID;
      enq_tag[s]  = src_rf_tag[s];
      enq_data[s] = DATA_W'(NULL_V);
      if (src_rf_v[s]) begin
        enq_v[s]    = VALID;
        enq_tag[s]  = TAG_W'(NULL_V);
        enq_data[s] = src_rf_data[s];
      end else if (src_rob_v[s]) begin
        enq_v[s]    = VALID;
        enq_tag[s]  = TAG_W'(NULL_V);
        enq_data[s] = src_rob_data[s];
      end else begin
        for (int k = 0; k < CDB_N; k++) begin
          if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == src_rf_tag[s])) begin
            enq_v[s]    = VALID;
            enq_tag[s]  = TAG_W'(NULL_V);
            enq_data[s] = cdb_data_i[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign disp_ready_o = (count_q != CNT_W'(DEPTH));
  // No pass-through at full: admission looks only at the registered count.
  assign enq        = disp_en_i & disp_ready_o & rdy_in & ~clear_i;
  assign head_valid = ent_valid_q[head_q];
  assign head_cls   = cls_q[head_q];

  always_comb begin
    class_full = alu_full_i;
    case (head_cls)
      CLS_LS:  class_full = ls_full_i;
      CLS_BR:  class_full = br_full_i;
      default: class_full = alu_full_i;
    endcase
  end

  assign issue = head_valid & ~class_full & rdy_in & ~clear_i;
  assign show  = head_valid & ~clear_i;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_valid_d = ent_valid_q;
    if (clear_i) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      ent_valid_d = '0;
    end else begin
      if (enq) begin
        ent_valid_d[tail_q] = VALID;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (issue) begin
        ent_valid_d[head_q] = INVALID;
        head_d              = head_q + PTR_W'(1);
      end
      if (enq && !issue) begin
        count_d = count_q + CNT_W'(1);
      end else if (!enq && issue) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ent_valid_q <= '0;
    end else if (rdy_in) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ent_valid_q <= ent_valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      op_q[tail_q]  <= op_i;
      imm_q[tail_q] <= imm_i;
      pc_q[tail_q]  <= pc_i;
      des_q[tail_q] <= des_i;
      bp_q[tail_q]  <= bp_i;
      cls_q[tail_q] <= op_class(32'(op_i));
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    for (genvar s = 0; s < 2; s++) begin : g_src
      dispatch_operand_slot #(
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .CDB_N (CDB_N)
      ) u_slot (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .en_i        (rdy_in),
        .clear_i     (clear_i),
        .load_i      (enq && (tail_q == PTR_W'(e))),
        .load_valid_i(enq_v[s]),
        .load_tag_i  (enq_tag[s]),
        .load_data_i (enq_data[s]),
        .cdb_valid_i (cdb_valid_i),
        .cdb_tag_i   (cdb_tag_i),
        .cdb_data_i  (cdb_data_i),
        .fwd_valid_o (fwd_v[s][e]),
        .fwd_tag_o   (fwd_tag[s][e]),
        .fwd_data_o  (fwd_data[s][e])
      );
    end
  end

  assign alu_we_o = issue & (head_cls == CLS_ALU);
  assign ls_we_o  = issue & (head_cls == CLS_LS);
  assign br_we_o  = issue & (head_cls == CLS_BR);

  assign op_o         = show ? op_q[head_q]  : '0;
  assign imm_o        = show ? imm_q[head_q] : '0;
  assign pc_o         = show ? pc_q[head_q]  : '0;
  assign des_o        = show ? des_q[head_q] : '0;
  assign bp_o         = show & bp_q[head_q];
  assign reg1_valid_o = show & fwd_v[0][head_q];
  assign reg1_tag_o   = show ? fwd_tag[0][head_q]  : '0;
  assign reg1_data_o  = show ? fwd_data[0][head_q] : '0;
  assign reg2_valid_o = show & fwd_v[1][head_q];
  assign reg2_tag_o   = show ? fwd_tag[1][head_q]  : '0;
  assign reg2_data_o  = show ? fwd_data[1][head_q] : '0;

endmodule
